game_round_scheduler: RTL and testbench

Round sequencer for the mental-arithmetic game. It fetches NUM_TERMS random terms from an external LFSR source over a req/valid handshake and accumulates their sum modulo 100. It then opens a timed answer window, grades the switch answer and runs ROUNDS rounds per game while keeping score. It owns the shared display path: it drives the single binary value fed to the BCD converter and the LED pattern, and selects which source is shown.

---
 rtl/game_round_scheduler.sv | 243 ++++++++++++++++++++++++
 tb/tb_game_round_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_scheduler.sv
// Round sequencer for the mental-arithmetic game: fetches terms, grades the answer, keeps score.
// Optional feature: define SCORE_DISPLAY_EN to show the final score before returning to IDLE.
module game_round_scheduler #(
   parameter int NUM_TERMS  = 5,
   parameter int SHOW_CYC   = 1,
   parameter int ENTRY_CYC  = 15,
   parameter int REVEAL_CYC = 4,
   parameter int ROUNDS     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       rnd_req,
   input  logic       rnd_valid,
   input  logic [4:0] rnd_data,
   input  logic [6:0] switch,
   input  logic       submit,
   output logic [7:0] disp_value,
   output logic [1:0] disp_sel,
   output logic [6:0] led,
   output logic       busy,
   output logic       round_done,
   output logic [3:0] score,
   output logic       game_over
);

   localparam int MAX_AB  = (ENTRY_CYC > SHOW_CYC) ? ENTRY_CYC : SHOW_CYC;
   localparam int TMR_MAX = (MAX_AB > REVEAL_CYC) ? MAX_AB : REVEAL_CYC;
   localparam int TW      = $clog2(TMR_MAX + 1);

   localparam logic [1:0] SEL_BLANK  = 2'd0;
   localparam logic [1:0] SEL_TERM   = 2'd1;
   localparam logic [1:0] SEL_SWITCH = 2'd2;
   localparam logic [1:0] SEL_SUM    = 2'd3;
   localparam logic [6:0] LED_ALL    = 7'h7F;
   localparam logic [6:0] LED_WRONG  = 7'b1010101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SHOW,
      S_BLANK,
      S_ENTRY,
      S_REVEAL
`ifdef SCORE_DISPLAY_EN
      , S_SCORE
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    term_cnt_q, term_cnt_d;
   logic [3:0]    round_cnt_q, round_cnt_d;
   logic [6:0]    sum_q, sum_d;
   logic [3:0]    score_q, score_d;
   logic          rnd_req_q, rnd_req_d;
   logic [7:0]    disp_value_q, disp_value_d;
   logic [1:0]    disp_sel_q, disp_sel_d;
   logic [6:0]    led_q, led_d;
   logic          busy_q, busy_d;
   logic          round_done_q, round_done_d;
   logic          game_over_q, game_over_d;

   logic [7:0]    sum_add;
   logic [6:0]    sum_wrap;
   logic          answer_ok;
   logic [3:0]    round_next;

   always_comb begin
      // Sum stays in 0..99, and 99 + 31 < 200, so one conditional subtract suffices.
      sum_add    = {1'b0, sum_q} + {3'b000, rnd_data};
      sum_wrap   = (sum_add >= 8'd100) ? 7'(sum_add - 8'd100) : sum_add[6:0];
      answer_ok  = (switch == sum_q);
      round_next = round_cnt_q + 4'd1;

      // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      timer_d      = timer_q;
      term_cnt_d   = term_cnt_q;
      round_cnt_d  = round_cnt_q;
      sum_d        = sum_q;
      score_d      = score_q;
      rnd_req_d    = rnd_req_q;
      disp_value_d = disp_value_q;
      disp_sel_d   = disp_sel_q;
      led_d        = led_q;
      round_done_d = 1'b0;
      game_over_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_FETCH;
               rnd_req_d   = 1'b1;
               score_d     = 4'd0;
               round_cnt_d = 4'd0;
               term_cnt_d  = 4'd0;
               sum_d       = 7'd0;
            end
         end
         S_FETCH: begin
            if (rnd_valid && rnd_req_q) begin
               state_d      = S_SHOW;
               rnd_req_d    = 1'b0;
               sum_d        = sum_wrap;
               term_cnt_d   = term_cnt_q + 4'd1;
               disp_value_d = {3'b000, rnd_data};
               disp_sel_d   = SEL_TERM;
               led_d        = {rnd_data, 2'b00};
               timer_d      = '0;
            end
         end
         S_SHOW: begin
            if (timer_q == TW'(SHOW_CYC - 1)) begin
               timer_d = '0;
               if (term_cnt_q < 4'(NUM_TERMS)) begin
                  state_d   = S_FETCH;
                  rnd_req_d = 1'b1;
               end else begin
                  state_d      = S_BLANK;
                  disp_value_d = 8'd0;
                  disp_sel_d   = SEL_BLANK;
                  led_d        = 7'd0;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_BLANK: begin
            state_d      = S_ENTRY;
            disp_sel_d   = SEL_SWITCH;
            disp_value_d = {1'b0, switch};
            timer_d      = '0;
         end
         S_ENTRY: begin
            disp_value_d = {1'b0, switch};
            if (submit || (timer_q == TW'(ENTRY_CYC - 1))) begin
               if (answer_ok && (score_q != 4'hF)) begin
                  score_d = score_q + 4'd1;
               end
               state_d      = S_REVEAL;
               disp_sel_d   = SEL_SUM;
               disp_value_d = {1'b0, sum_q};
               led_d        = answer_ok ? LED_ALL : LED_WRONG;
               round_done_d = 1'b1;
               timer_d      = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_REVEAL: begin
            if (timer_q == TW'(REVEAL_CYC - 1)) begin
               timer_d     = '0;
               round_cnt_d = round_next;
               if (round_next < 4'(ROUNDS)) begin
                  state_d      = S_FETCH;
                  rnd_req_d    = 1'b1;
                  sum_d        = 7'd0;
                  term_cnt_d   = 4'd0;
                  disp_value_d = 8'd0;
                  disp_sel_d   = SEL_BLANK;
                  led_d        = 7'd0;
               end else begin
`ifdef SCORE_DISPLAY_EN
                  state_d      = S_SCORE;
                  disp_value_d = {4'd0, score_q};
                  disp_sel_d   = SEL_SUM;
                  led_d        = (score_q == 4'(ROUNDS)) ? LED_ALL : 7'd0;
`else
                  state_d      = S_IDLE;
                  game_over_d  = 1'b1;
                  disp_value_d = 8'd0;
                  disp_sel_d   = SEL_BLANK;
                  led_d        = 7'd0;
`endif
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
`ifdef SCORE_DISPLAY_EN
         S_SCORE: begin
            if (timer_q == TW'(REVEAL_CYC - 1)) begin
               timer_d      = '0;
               state_d      = S_IDLE;
               game_over_d  = 1'b1;
               disp_value_d = 8'd0;
               disp_sel_d   = SEL_BLANK;
               led_d        = 7'd0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         term_cnt_q   <= 4'd0;
         round_cnt_q  <= 4'd0;
         sum_q        <= 7'd0;
         score_q      <= 4'd0;
         rnd_req_q    <= 1'b0;
         disp_value_q <= 8'd0;
         disp_sel_q   <= 2'd0;
         led_q        <= 7'd0;
         busy_q       <= 1'b0;
         round_done_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         term_cnt_q   <= term_cnt_d;
         round_cnt_q  <= round_cnt_d;
         sum_q        <= sum_d;
         score_q      <= score_d;
         rnd_req_q    <= rnd_req_d;
         disp_value_q <= disp_value_d;
         disp_sel_q   <= disp_sel_d;
         led_q        <= led_d;
         busy_q       <= busy_d;
         round_done_q <= round_done_d;
         game_over_q  <= game_over_d;
      end
   end

   assign rnd_req    = rnd_req_q;
   assign disp_value = disp_value_q;
   assign disp_sel   = disp_sel_q;
   assign led        = led_q;
   assign busy       = busy_q;
   assign round_done = round_done_q;
   assign score      = score_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Directed bench for game_round_scheduler (ROUNDS=2); expectations follow SCORE_DISPLAY_EN if defined.
module tb_game_round_scheduler;

   localparam int TB_ROUNDS = 2;
   localparam int TB_ENTRY  = 15;

   typedef logic [4:0] terms_t [5];

   logic       clk = 1'b0;
   logic       rst, start, rnd_valid, submit;
   logic [4:0] rnd_data;
   logic [6:0] switch;
   logic       rnd_req, busy, round_done, game_over;
   logic [7:0] disp_value;
   logic [1:0] disp_sel;
   logic [6:0] led;
   logic [3:0] score;

   int tests_run    = 0;
   int tests_failed = 0;

   game_round_scheduler #(
      .NUM_TERMS (5),
      .SHOW_CYC  (1),
      .ENTRY_CYC (TB_ENTRY),
      .REVEAL_CYC(4),
      .ROUNDS    (TB_ROUNDS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rnd_req   (rnd_req),
      .rnd_valid (rnd_valid),
      .rnd_data  (rnd_data),
      .switch    (switch),
      .submit    (submit),
      .disp_value(disp_value),
      .disp_sel  (disp_sel),
      .led       (led),
      .busy      (busy),
      .round_done(round_done),
      .score     (score),
      .game_over (game_over)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_term(input logic [4:0] t, input int dly);
      int w = 0;
      while (!rnd_req && w < 20) begin
         tick();
         w++;
      end
      check("req_up", rnd_req, 1);
      for (int i = 0; i < dly; i++) begin
         tick();
         check("req_hold", rnd_req, 1);
      end
      rnd_valid = 1'b1;
      rnd_data  = t;
      tick();
      rnd_valid = 1'b0;
      check("term_val", disp_value, {3'b000, t});
      check("term_sel", disp_sel, 1);
      check("term_led", led, {t, 2'b00});
      check("req_drop", rnd_req, 0);
   endtask

   task automatic end_game(input logic [3:0] exp_score);
`ifdef SCORE_DISPLAY_EN
      check("score_sel", disp_sel, 3);
      check("score_val", disp_value, {4'd0, exp_score});
      check("score_led", led, (exp_score == 4'(TB_ROUNDS)) ? 7'h7F : 7'h00);
      check("go_early", game_over, 0);
      check("score_busy", busy, 1);
      repeat (3) tick();
      check("score_hold", disp_sel, 3);
      tick();
`endif
      check("go_pulse", game_over, 1);
      check("idle_busy", busy, 0);
      check("idle_sel", disp_sel, 0);
      check("score_keep", score, exp_score);
      tick();
      check("go_once", game_over, 0);
   endtask

   task automatic play_round(input terms_t tv, input int dly, input logic [6:0] sw,
                             input int sub_at, input logic [6:0] exp_sum, input logic exp_ok,
                             input logic [3:0] exp_score, input logic last);
      int n;
      for (int i = 0; i < 5; i++) fetch_term(tv[i], dly);
      tick();
      check("blank_sel", disp_sel, 0);
      check("blank_val", disp_value, 0);
      check("blank_led", led, 0);
      switch = sw;
      tick();
      check("entry_sel", disp_sel, 2);
      check("entry_val", disp_value, {1'b0, sw});
      n = 0;
      do begin
         n++;
         submit = (n == sub_at);
         tick();
         submit = 1'b0;
      end while (!round_done && n < 30);
      check("entry_len", n, (sub_at > 0) ? sub_at : TB_ENTRY);
      check("rd_pulse", round_done, 1);
      check("rev_sel", disp_sel, 3);
      check("rev_val", disp_value, {1'b0, exp_sum});
      check("rev_led", led, exp_ok ? 7'h7F : 7'b1010101);
      check("rev_score", score, exp_score);
      tick();
      check("rd_once", round_done, 0);
      check("rev_hold", disp_sel, 3);
      repeat (3) tick();
      if (!last) begin
         check("next_req", rnd_req, 1);
         check("next_sel", disp_sel, 0);
      end else begin
         end_game(exp_score);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      terms_t tv;
      rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; submit = 1'b0;
      rnd_data = 5'd0; switch = 7'd0;
      repeat (2) tick();
      check("rst_req", rnd_req, 0);
      check("rst_val", disp_value, 0);
      check("rst_sel", disp_sel, 0);
      check("rst_led", led, 0);
      check("rst_busy", busy, 0);
      check("rst_score", score, 0);
      check("rst_go", game_over, 0);
      rst = 1'b0;
      tick();

      // Game 1: two correct rounds, second with a slow source.
      do_start();
      check("g1_req", rnd_req, 1);
      check("g1_busy", busy, 1);
      tv = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd11};
      play_round(tv, 0, 7'd35, 1, 7'd35, 1'b1, 4'd1, 1'b0);
      tv = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
      play_round(tv, 2, 7'd55, 3, 7'd55, 1'b1, 4'd2, 1'b1);
      tick();
      check("idle_hold_score", score, 2);

      // Game 2: wrong answer, then window timeout.
      do_start();
      check("g2_score_clr", score, 0);
      tv = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
      play_round(tv, 0, 7'd127, 2, 7'd55, 1'b0, 4'd0, 1'b0);
      tv = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
      play_round(tv, 0, 7'd0, 0, 7'd15, 1'b0, 4'd0, 1'b1);

      // Game 3: submit on the final window cycle, ignored pulses, then reset mid-ENTRY.
      do_start();
      tv = '{5'd20, 5'd20, 5'd20, 5'd20, 5'd19};
      play_round(tv, 0, 7'd99, TB_ENTRY, 7'd99, 1'b1, 4'd1, 1'b0);
      do_start();
      check("start_ign_req", rnd_req, 1);
      check("start_ign_score", score, 1);
      fetch_term(5'd1, 0);
      submit = 1'b1;
      tick();
      submit = 1'b0;
      check("submit_ign", rnd_req, 1);
      for (int i = 2; i <= 5; i++) fetch_term(5'(i), 0);
      tick();
      switch = 7'd0;
      tick();
      check("g3_entry", disp_sel, 2);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_sel", disp_sel, 0);
      check("mid_rst_val", disp_value, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_score", score, 0);
      check("mid_rst_rd", round_done, 0);

      // Reset while a term is being offered.
      do_start();
      rnd_valid = 1'b1;
      rnd_data  = 5'd9;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rnd_valid = 1'b0;
      check("fetch_rst_val", disp_value, 0);
      check("fetch_rst_req", rnd_req, 0);
      check("fetch_rst_busy", busy, 0);

      // A term offered in IDLE is ignored.
      rnd_valid = 1'b1;
      rnd_data  = 5'd17;
      tick();
      rnd_valid = 1'b0;
      check("idle_valid_val", disp_value, 0);
      check("idle_valid_busy", busy, 0);

      // Game 4: fresh start after reset begins at round 1.
      do_start();
      check("g4_req", rnd_req, 1);
      check("g4_score", score, 0);
      tv = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd11};
      play_round(tv, 0, 7'd35, 1, 7'd35, 1'b1, 4'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
